bcd_split_seq: RTL and testbench

Sequential, parametrised binary-to-BCD digit splitter for the digital-clock display path. It accepts a WIDTH-bit unsigned value over a valid/ready handshake and converts it with an iterative shift-and-add-3 (double-dabble) engine, one bit per clock. It returns DIGITS packed BCD digits plus an overflow flag. It sits between the counters and the seven-segment multiplexer and generalises the fixed 16-bit thousands/hundreds splitter to any width and digit count.

---
 rtl/bcd_split_seq_if.sv | 23 ++
 rtl/bcd_split_seq.sv | 106 ++++++++++
 tb/tb_bcd_split_seq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_split_seq_if.sv
// rtl/bcd_split_seq_if.sv - handshake bundle for the binary-to-BCD splitter
interface bcd_split_seq_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      total;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;

    modport slave (
        input  in_valid, total, out_ready,
        output in_ready, out_valid, bcd, ovf
    );

    modport master (
        output in_valid, total, out_ready,
        input  in_ready, out_valid, bcd, ovf
    );
endinterface

// File: rtl/bcd_split_seq.sv
// rtl/bcd_split_seq.sv - iterative double-dabble splitter, optional BCD_SPLIT_LZ_BLANK_EN blanking
module bcd_split_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    bcd_split_seq_if.slave    bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [AW-1:0]   acc_q, acc_d, adj;
    logic [CW-1:0]   cnt_q;
    logic            sticky_q, sticky_d, carry;
    logic [AW-1:0]   bcd_q, bcd_d;
    logic            ovf_q;
    logic            last_step;

    assign last_step = (cnt_q == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = CONV;
            CONV:    if (last_step) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.bcd       = bcd_q;
        bus.ovf       = ovf_q;
    end

    // One double-dabble step; the bit pushed out of the top digit marks overflow.
    always_comb begin
        adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
        {carry, acc_d, shift_d} = {adj, shift_q, 1'b0};
        sticky_d = sticky_q | carry;
    end

    always_comb begin
        bcd_d = acc_d;
        if (sticky_d) begin
            for (int i = 0; i < DIGITS; i++) bcd_d[4*i +: 4] = 4'h9;
        end
`ifdef BCD_SPLIT_LZ_BLANK_EN
        else begin : lz_blank
            logic seen;
            seen = 1'b0;
            // Ones digit (i == 0) is never blanked so zero still shows.
            for (int i = DIGITS - 1; i >= 1; i--) begin
                if (!seen && acc_d[4*i +: 4] == 4'h0) bcd_d[4*i +: 4] = 4'hF;
                else                                  seen = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    shift_q  <= bus.total;
                    acc_q    <= '0;
                    sticky_q <= 1'b0;
                    cnt_q    <= CW'(WIDTH);
                end
                CONV: begin
                    shift_q  <= shift_d;
                    acc_q    <= acc_d;
                    sticky_q <= sticky_d;
                    cnt_q    <= cnt_q - CW'(1);
                    if (last_step) begin
                        bcd_q <= bcd_d;
                        ovf_q <= sticky_d;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_split_seq.sv
// tb/tb_bcd_split_seq.sv - randomized self-checking bench for bcd_split_seq
module tb_bcd_split_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    time  last_accept_t = 0;

    always #5 clk = ~clk;

    bcd_split_seq_if #(.WIDTH(16), .DIGITS(5)) a ();
    bcd_split_seq_if #(.WIDTH(16), .DIGITS(4)) b ();

    bcd_split_seq #(.WIDTH(16), .DIGITS(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(a));
    bcd_split_seq #(.WIDTH(16), .DIGITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b));

    function automatic void model(input int v, input int nd, output logic [19:0] r, output logic o);
        int p;
        int x;
        p = 1;
        x = v;
        r = '0;
        for (int i = 0; i < nd; i++) p = p * 10;
        if (v >= p) begin
            o = 1'b1;
            for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'h9;
        end else begin
            o = 1'b0;
            for (int i = 0; i < nd; i++) begin
                r[4*i +: 4] = 4'(x % 10);
                x = x / 10;
            end
`ifdef BCD_SPLIT_LZ_BLANK_EN
            begin
                int len;
                len = 1;
                x = v;
                while (x >= 10) begin x = x / 10; len++; end
                for (int i = len; i < nd; i++) r[4*i +: 4] = 4'hF;
            end
`endif
        end
    endfunction

    task automatic drive_in(input logic vld, input int v);
        a.in_valid = vld; b.in_valid = vld;
        a.total = 16'(v); b.total = 16'(v);
    endtask

    // Caller is at a negedge with both blocks idle.
    task automatic convert_check(input int v);
        logic [19:0] e5, e4;
        logic o5, o4;
        int n;
        model(v, 5, e5, o5);
        model(v, 4, e4, o4);
        checks++;
        if (a.in_ready !== 1'b1 || b.in_ready !== 1'b1) begin
            failures++; $display("FAIL ready_before v=%0d got=%b%b exp=11", v, a.in_ready, b.in_ready);
        end
        drive_in(1'b1, v);
        @(posedge clk);
        @(negedge clk);
        last_accept_t = $time;
        drive_in(1'b0, $urandom_range(0, 65535));
        n = 0;
        while (a.out_valid !== 1'b1 && n < 40) begin
            checks++;
            if (a.in_ready !== 1'b0) begin
                failures++; $display("FAIL busy_ready v=%0d got=%b exp=0", v, a.in_ready);
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 16) begin
            failures++; $display("FAIL latency v=%0d got=%0d exp=16", v, n);
        end
        checks++;
        if (b.out_valid !== 1'b1) begin
            failures++; $display("FAIL valid4 v=%0d got=%b exp=1", v, b.out_valid);
        end
        checks++;
        if (a.bcd !== e5 || a.ovf !== o5) begin
            failures++; $display("FAIL result5 v=%0d got=%h/%b exp=%h/%b", v, a.bcd, a.ovf, e5, o5);
        end
        checks++;
        if (b.bcd !== e4[15:0] || b.ovf !== o4) begin
            failures++; $display("FAIL result4 v=%0d got=%h/%b exp=%h/%b", v, b.bcd, b.ovf, e4[15:0], o4);
        end
        @(negedge clk);
        checks++;
        if (a.in_ready !== 1'b1 || a.out_valid !== 1'b0 || b.in_ready !== 1'b1) begin
            failures++; $display("FAIL post_hs v=%0d got=%b%b%b exp=101", v, a.in_ready, a.out_valid, b.in_ready);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (a.in_ready !== 1'b1 || a.out_valid !== 1'b0 || a.bcd !== 20'h0 || a.ovf !== 1'b0) begin
            failures++; $display("FAIL reset_state got=%b%b %h %b exp=10 00000 0", a.in_ready, a.out_valid, a.bcd, a.ovf);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        int vals[8] = '{1234, 65535, 0, 9999, 10000, 10500, 42, 99};
        foreach (vals[i]) convert_check(vals[i]);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0:       convert_check($urandom_range(9990, 10010));
                1:       convert_check($urandom_range(0, 120));
                default: convert_check($urandom_range(0, 65535));
            endcase
        end
    endtask

    task automatic test_back_to_back();
        time t0;
        convert_check($urandom_range(0, 65535));
        t0 = last_accept_t;
        convert_check($urandom_range(0, 65535));
        checks++;
        if (last_accept_t - t0 != 180) begin
            failures++; $display("FAIL throughput got=%0t exp=180", last_accept_t - t0);
        end
    endtask

    task automatic test_backpressure();
        logic [19:0] e5, e4;
        logic o5, o4;
        int v, n;
        v = $urandom_range(0, 65535);
        model(v, 5, e5, o5);
        model(v, 4, e4, o4);
        a.out_ready = 1'b0; b.out_ready = 1'b0;
        drive_in(1'b1, v);
        @(posedge clk);
        @(negedge clk);
        drive_in(1'b0, 0);
        n = 0;
        while (a.out_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (a.out_valid !== 1'b1 || a.in_ready !== 1'b0 || a.bcd !== e5 || a.ovf !== o5
                || b.bcd !== e4[15:0] || b.ovf !== o4) begin
                failures++;
                $display("FAIL bp_hold c=%0d got=%b%b %h/%b exp=10 %h/%b", c, a.out_valid, a.in_ready, a.bcd, a.ovf, e5, o5);
            end
            drive_in(c == 3, $urandom_range(0, 65535));
            @(negedge clk);
        end
        drive_in(1'b0, 0);
        a.out_ready = 1'b1; b.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (a.out_valid !== 1'b0 || a.in_ready !== 1'b1 || a.bcd !== e5) begin
            failures++; $display("FAIL bp_release got=%b%b %h exp=01 %h", a.out_valid, a.in_ready, a.bcd, e5);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (a.out_valid !== 1'b0 || a.in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_idle got=%b%b exp=01", a.out_valid, a.in_ready);
        end
    endtask

    task automatic test_reset_mid_conv();
        convert_check(1234);
        drive_in(1'b1, 54321);
        @(posedge clk);
        @(negedge clk);
        drive_in(1'b0, 0);
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (a.in_ready !== 1'b1 || a.out_valid !== 1'b0 || a.bcd !== 20'h0 || a.ovf !== 1'b0 || b.bcd !== 16'h0) begin
            failures++; $display("FAIL async_reset got=%b%b %h %b exp=10 00000 0", a.in_ready, a.out_valid, a.bcd, a.ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        convert_check(42);
    endtask

    initial begin
        drive_in(1'b0, 0);
        a.out_ready = 1'b1; b.out_ready = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_conv();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
